// File: rtl/scope_pkg.sv
// Shared scope definitions: screen geometry, capture FSM encoding and the
// sample-to-screen-row mapping used by both the trace writer and the overlay cursor.
package scope_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int Y_MAX    = SCREEN_H - 1;
   localparam int SAMPLE_W = 12;
   localparam int Y_W      = 10;

   typedef enum logic [1:0] {
      ARM     = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } capture_state_e;

   // 4095*15 fits in 16 bits, and the shifted result never exceeds Y_MAX.
   function automatic logic [Y_W-1:0] sample_to_y(input logic [SAMPLE_W-1:0] s);
      logic [15:0] scaled;
      scaled = (16'(s) * 16'd15) >> 7;
      return Y_W'(Y_MAX) - scaled[Y_W-1:0];
   endfunction

endpackage

// File: rtl/trace_capture_writer_if.sv
// Sample input and trace RAM write port of the scope trace writer.
// master = the writer, slave = the sampler/RAM/display side.
interface trace_capture_writer_if
   import scope_pkg::*;
#(
   parameter int S_W = SAMPLE_W,
   parameter int D_W = Y_W
);

   logic           sample_valid;
   logic [S_W-1:0] sample;
   logic           wr_en;
   logic           wr_bank;
   logic [9:0]     wr_addr;
   logic [D_W-1:0] wr_data;
   logic           disp_bank;

   modport master (
      input  sample_valid, sample,
      output wr_en, wr_bank, wr_addr, wr_data, disp_bank
   );

   modport slave (
      output sample_valid, sample,
      input  wr_en, wr_bank, wr_addr, wr_data, disp_bank
   );

endinterface

// File: rtl/sample_decimator.sv
// Keeps one of every decim+1 valid samples; the ratio is latched on the first
// cycle after reset or clear so it stays fixed for a whole trace.
module sample_decimator (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        valid,
   input  logic [15:0] decim,
   output logic        accept
);

   logic [15:0] dec_cnt;
   logic [15:0] decim_q;
   logic [15:0] decim_eff;
   logic        fresh;

   // While fresh, the live input is the ratio being latched this cycle.
   assign decim_eff = fresh ? decim : decim_q;
   assign accept    = valid && !clear && (dec_cnt == decim_eff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_cnt <= '0;
         decim_q <= '0;
         fresh   <= 1'b1;
      end else if (clear) begin
         dec_cnt <= '0;
         fresh   <= 1'b1;
      end else begin
         if (fresh) begin
            decim_q <= decim;
            fresh   <= 1'b0;
         end
         if (valid) begin
            dec_cnt <= accept ? 16'd0 : dec_cnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/trace_capture_writer.sv
// Write side of the double-buffered scope trace memory: waits for a trigger, writes
// one screen of scaled Y coordinates into the back bank, swaps banks at vblank.
module trace_capture_writer
   import scope_pkg::*;
#(
   parameter int DEPTH        = SCREEN_W,
   parameter int AUTO_TIMEOUT = 65535
) (
   input  logic                    clk,
   input  logic                    rst,
   trace_capture_writer_if.master  bus,
   input  logic [15:0]             decim,
   input  logic [SAMPLE_W-1:0]     trig_level,
   input  logic                    trig_en,
   input  logic                    frame_done,
   output logic [1:0]              state_o
);

   localparam logic [9:0]  LAST_COL     = 10'(DEPTH - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(AUTO_TIMEOUT - 1);

   capture_state_e state, state_nx;
   logic [9:0]     col;
   logic [9:0]     write_col;
   logic [15:0]    timeout_cnt;
   logic           prev_below;
   logic           accept;
   logic           trigger;
   logic           do_write;
   logic           swap;

   // A sample arriving with the swap pulse is dropped: HOLD never writes.
   assign swap = (state == HOLD) && frame_done;

   sample_decimator u_decim (
      .clk    (clk),
      .rst    (rst),
      .clear  (swap),
      .valid  (bus.sample_valid),
      .decim  (decim),
      .accept (accept)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ARM;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      trigger   = 1'b0;
      do_write  = 1'b0;
      write_col = col;
      case (state)
         ARM: begin
            if (accept) begin
               trigger = !trig_en
                      || (prev_below && (bus.sample >= trig_level))
                      || (timeout_cnt == TIMEOUT_LAST);
               if (trigger) begin
                  do_write  = 1'b1;
                  write_col = '0;
                  state_nx  = (DEPTH == 1) ? HOLD : CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (accept) begin
               do_write = 1'b1;
               if (col == LAST_COL) state_nx = HOLD;
            end
         end
         HOLD: begin
            if (frame_done) state_nx = ARM;
         end
         default: state_nx = ARM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col         <= '0;
         timeout_cnt <= '0;
         prev_below  <= 1'b0;
      end else begin
         case (state)
            ARM: begin
               if (accept) begin
                  prev_below  <= (bus.sample < trig_level);
                  timeout_cnt <= timeout_cnt + 16'd1;
                  if (trigger) col <= 10'd1;
               end
            end
            CAPTURE: begin
               if (accept) col <= col + 10'd1;
            end
            HOLD: begin
               if (frame_done) begin
                  col         <= '0;
                  timeout_cnt <= '0;
                  prev_below  <= 1'b0;
               end
            end
            default: col <= '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
      end else begin
         bus.wr_en <= do_write;
         if (do_write) begin
            bus.wr_addr <= write_col;
            bus.wr_data <= sample_to_y(bus.sample);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       bus.disp_bank <= 1'b0;
      else if (swap) bus.disp_bank <= ~bus.disp_bank;
   end

   assign bus.wr_bank = ~bus.disp_bank;
   assign state_o     = state;

endmodule

// File: tb/tb_trace_capture_writer.sv
// Directed bench for trace_capture_writer: free-run, edge and forced triggers,
// decimation, bank swap timing and mid-trace reset.
module tb_trace_capture_writer;

   localparam int DEPTH = 640;
   localparam int AT    = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] decim;
   logic [11:0] trig_level;
   logic        trig_en;
   logic        frame_done;
   logic [1:0]  state_o;

   trace_capture_writer_if bus ();

   trace_capture_writer #(
      .DEPTH        (DEPTH),
      .AUTO_TIMEOUT (AT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .decim      (decim),
      .trig_level (trig_level),
      .trig_en    (trig_en),
      .frame_done (frame_done),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   int         total_writes = 0;
   int         addr_err     = 0;
   int         next_addr    = 0;
   logic [9:0] last_addr    = '0;
   logic       last_bank    = 1'b0;
   int         trace_mem [DEPTH];

   // Records every RAM write and flags any address that is not 0 or the successor of the last one.
   always @(negedge clk) begin
      if (bus.wr_en) begin
         total_writes++;
         if ((bus.wr_addr != 10'd0 && int'(bus.wr_addr) != next_addr) || int'(bus.wr_addr) >= DEPTH)
            addr_err++;
         next_addr = int'(bus.wr_addr) + 1;
         last_addr = bus.wr_addr;
         last_bank = bus.wr_bank;
         if (int'(bus.wr_addr) < DEPTH) trace_mem[bus.wr_addr] = int'(bus.wr_data);
      end
   end

   function automatic int y_ref(input int s);
      return 479 - (s * 15) / 128;
   endfunction

   task automatic checkOutput(input string tag, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input int s);
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sample       = 12'(s);
      @(negedge clk);
      bus.sample_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseFrame(input logic with_sample);
      @(negedge clk);
      frame_done = 1'b1;
      if (with_sample) begin
         bus.sample_valid = 1'b1;
         bus.sample       = 12'd0;
      end
      @(negedge clk);
      frame_done       = 1'b0;
      bus.sample_valid = 1'b0;
   endtask

   int w0;

   initial begin
      rst              = 1'b1;
      bus.sample_valid = 1'b0;
      bus.sample       = '0;
      decim            = 16'd0;
      trig_level       = 12'd2048;
      trig_en          = 1'b0;
      frame_done       = 1'b0;
      idle(3);

      checkOutput("rst_wr_en",     int'(bus.wr_en),     0);
      checkOutput("rst_wr_addr",   int'(bus.wr_addr),   0);
      checkOutput("rst_wr_data",   int'(bus.wr_data),   0);
      checkOutput("rst_disp_bank", int'(bus.disp_bank), 0);
      checkOutput("rst_wr_bank",   int'(bus.wr_bank),   1);
      checkOutput("rst_state",     int'(state_o),       0);
      rst = 1'b0;
      idle(2);

      // Free-run ramp, every sample kept
      w0 = total_writes;
      for (int i = 0; i < DEPTH; i++) applyStimulus(i);
      idle(2);
      checkOutput("t1_writes",  total_writes - w0, 640);
      checkOutput("t1_col0",    trace_mem[0],      479);
      checkOutput("t1_col320",  trace_mem[320],    442);
      checkOutput("t1_col639",  trace_mem[639],    405);
      checkOutput("t1_bank",    int'(last_bank),   1);
      checkOutput("t1_hold",    int'(state_o),     2);
      applyStimulus(100);
      idle(2);
      checkOutput("t1_hold_nowrite", total_writes - w0, 640);
      pulseFrame(1'b0);
      checkOutput("t1_swap",  int'(bus.disp_bank), 1);
      checkOutput("t1_arm",   int'(state_o),       0);

      // Rising-edge trigger through 2048
      trig_en    = 1'b1;
      trig_level = 12'd2048;
      w0 = total_writes;
      applyStimulus(3000);
      applyStimulus(1000);
      applyStimulus(1500);
      applyStimulus(2047);
      idle(2);
      checkOutput("t2_no_early", total_writes - w0, 0);
      applyStimulus(2048);
      idle(2);
      checkOutput("t2_trig_write", total_writes - w0, 1);
      checkOutput("t2_col0",       trace_mem[0],      239);
      checkOutput("t2_bank",       int'(last_bank),   0);
      for (int i = 1; i < DEPTH; i++) applyStimulus((i * 37) % 4096);
      idle(2);
      checkOutput("t2_writes", total_writes - w0, 640);
      checkOutput("t2_col639", trace_mem[639],    109);
      checkOutput("t2_col1",   trace_mem[1],      y_ref(37));
      pulseFrame(1'b0);
      checkOutput("t2_swap", int'(bus.disp_bank), 0);

      // Held DC above level: only the timeout can trigger
      w0 = total_writes;
      for (int i = 0; i < AT - 1; i++) applyStimulus(3000);
      idle(2);
      checkOutput("t6_no_trig", total_writes - w0, 0);
      applyStimulus(3000);
      idle(2);
      checkOutput("t6_forced",  total_writes - w0, 1);
      checkOutput("t6_col0",    trace_mem[0],      128);
      checkOutput("t6_capture", int'(state_o),     1);
      for (int i = 0; i < 100; i++) applyStimulus(3000);
      pulseFrame(1'b0);
      checkOutput("t4_cap_noswap", int'(bus.disp_bank), 0);
      checkOutput("t4_cap_state",  int'(state_o),       1);
      for (int i = 0; i < 539; i++) applyStimulus(3000);
      idle(2);
      checkOutput("t6_writes", total_writes - w0, 640);
      checkOutput("t6_hold",   int'(state_o),     2);
      decim   = 16'd3;
      trig_en = 1'b0;
      pulseFrame(1'b1);
      checkOutput("t4_hold_swap", int'(bus.disp_bank), 1);
      idle(2);
      checkOutput("t4_drop_sample", total_writes - w0, 640);
      checkOutput("t4_arm",         int'(state_o),     0);

      // Decimate by 4; ratio change mid-capture must be ignored
      w0 = total_writes;
      for (int k = 0; k < 2560; k++) begin
         if (k == 1000) decim = 16'd0;
         applyStimulus(k);
         if (k == 2558) begin
            idle(1);
            checkOutput("t3_writes_2559", total_writes - w0, 639);
         end
      end
      idle(2);
      checkOutput("t3_writes", total_writes - w0, 640);
      checkOutput("t3_col0",   trace_mem[0],      479);
      checkOutput("t3_col100", trace_mem[100],    432);
      checkOutput("t3_col320", trace_mem[320],    329);
      checkOutput("t3_col639", trace_mem[639],    180);
      checkOutput("t3_bank",   int'(last_bank),   0);
      checkOutput("t3_hold",   int'(state_o),     2);
      pulseFrame(1'b0);
      checkOutput("t3_swap", int'(bus.disp_bank), 0);

      // Reset in the middle of a trace
      for (int i = 0; i <= 300; i++) applyStimulus(i + 500);
      idle(2);
      checkOutput("t5_col300", int'(last_addr), 300);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("t5_wr_en",     int'(bus.wr_en),     0);
      checkOutput("t5_wr_addr",   int'(bus.wr_addr),   0);
      checkOutput("t5_wr_data",   int'(bus.wr_data),   0);
      checkOutput("t5_disp_bank", int'(bus.disp_bank), 0);
      checkOutput("t5_state",     int'(state_o),       0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      w0 = total_writes;
      applyStimulus(4095);
      idle(2);
      checkOutput("t5_first_write", total_writes - w0, 1);
      checkOutput("t5_first_addr",  int'(last_addr),   0);
      checkOutput("t5_col0",        trace_mem[0],      0);
      for (int i = 1; i < DEPTH; i++) applyStimulus(i);
      idle(2);
      checkOutput("t5_writes", total_writes - w0, 640);
      checkOutput("t5_hold",   int'(state_o),     2);

      checkOutput("addr_seq", addr_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
